// File: rtl/song_sequencer_if.sv
// Score ROM read port and note handshake between the song sequencer (master)
// and its environment: score ROM plus tone generator (slave).
interface song_sequencer_if #(
    parameter int ROM_AW   = 8,
    parameter int PERIOD_W = 17,
    parameter int LEN_W    = 11
);
    logic [ROM_AW-1:0]         rom_addr;
    logic [PERIOD_W+LEN_W+1:0] rom_data;
    logic                      note_valid;
    logic                      note_ready;
    logic [PERIOD_W-1:0]       note_period;
    logic [LEN_W-1:0]          note_len;
    logic                      note_rest;

    modport master (
        output rom_addr,
        input  rom_data,
        output note_valid,
        input  note_ready,
        output note_period,
        output note_len,
        output note_rest
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  note_valid,
        output note_ready,
        input  note_period,
        input  note_len,
        input  note_rest
    );
endinterface

// File: rtl/song_sequencer.sv
// Buzzer playback controller: song select, play/pause, note fetch and issue.
// Optional feature macro SONG_LOOP_EN: restart the song at its base on end-of-song.
module song_sequencer #(
    parameter int ROM_AW    = 8,
    parameter int PERIOD_W  = 17,
    parameter int LEN_W     = 11,
    parameter int NUM_SONGS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_next,
    input  logic                    btn_play,
    song_sequencer_if.master        bus,
    output logic [1:0]              song_idx,
    output logic                    playing,
    output logic                    song_done
);
    localparam int DW = PERIOD_W + LEN_W + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_ISSUE  = 3'd3,
        S_PAUSED = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;
    logic                  note_valid_q, note_valid_d;
    logic [PERIOD_W-1:0]   note_period_q, note_period_d;
    logic [LEN_W-1:0]      note_len_q, note_len_d;
    logic                  note_rest_q, note_rest_d;
    logic [1:0]            song_idx_q, song_idx_d;
    logic                  playing_q, playing_d;
    logic                  song_done_q, song_done_d;
    logic                  pause_pending_q, pause_pending_d;
    logic                  ovf_q, ovf_d;
    logic                  eos_s;
    logic                  pause_eff_s;
    logic [1:0]            next_idx_s;

    function automatic logic [ROM_AW-1:0] base_of(input logic [1:0] idx);
        base_of = ROM_AW'({idx, 6'd0});
    endfunction

    function automatic logic [1:0] next_song(input logic [1:0] idx);
        if ({30'd0, idx} >= 32'(NUM_SONGS - 1)) begin
            next_song = 2'd0;
        end else begin
            next_song = idx + 2'd1;
        end
    endfunction

    // An accepted entry at offset 63 forces end-of-song on the following latch.
    assign eos_s      = bus.rom_data[DW-1] | ovf_q;
    assign next_idx_s = next_song(song_idx_q);
    // Pause decision for this cycle, including a same-cycle play press or cancel.
    assign pause_eff_s = playing_q ? btn_play : (pause_pending_q & ~btn_play);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; song change overrides every state.
    always_comb begin
        state_d = S_IDLE;
        if (btn_next) begin
            if (playing_q) begin
                state_d = btn_play ? S_PAUSED : S_FETCH;
            end else begin
                state_d = btn_play ? S_FETCH : S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE:   state_d = btn_play ? S_FETCH : S_IDLE;
                S_FETCH:  state_d = S_LATCH;
                S_LATCH: begin
                    if (eos_s) begin
`ifdef SONG_LOOP_EN
                        state_d = pause_eff_s ? S_PAUSED : S_FETCH;
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.note_ready) begin
                        state_d = pause_eff_s ? S_PAUSED : S_FETCH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_PAUSED: state_d = btn_play ? S_FETCH : S_PAUSED;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values.
    always_comb begin
        rom_addr_d      = rom_addr_q;
        note_valid_d    = note_valid_q;
        note_period_d   = note_period_q;
        note_len_d      = note_len_q;
        note_rest_d     = note_rest_q;
        song_idx_d      = song_idx_q;
        playing_d       = playing_q;
        song_done_d     = 1'b0;
        pause_pending_d = pause_pending_q;
        ovf_d           = ovf_q;
        if (btn_next) begin
            song_idx_d      = next_idx_s;
            rom_addr_d      = base_of(next_idx_s);
            pause_pending_d = 1'b0;
            ovf_d           = 1'b0;
            note_valid_d    = 1'b0;
            playing_d       = btn_play ? ~playing_q : playing_q;
        end else begin
            if (btn_play) begin
                if ((state_q == S_IDLE) || (state_q == S_PAUSED) || !playing_q) begin
                    playing_d       = 1'b1;
                    pause_pending_d = 1'b0;
                end else begin
                    playing_d       = 1'b0;
                    pause_pending_d = 1'b1;
                end
            end else begin
                playing_d       = playing_q;
                pause_pending_d = pause_pending_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (btn_play) begin
                        rom_addr_d = base_of(song_idx_q);
                    end else begin
                        rom_addr_d = rom_addr_q;
                    end
                end
                S_LATCH: begin
                    if (eos_s) begin
                        song_done_d     = 1'b1;
                        rom_addr_d      = base_of(song_idx_q);
                        ovf_d           = 1'b0;
                        pause_pending_d = 1'b0;
`ifndef SONG_LOOP_EN
                        playing_d       = 1'b0;
`endif
                    end else begin
                        note_period_d = bus.rom_data[PERIOD_W-1:0];
                        note_len_d    = bus.rom_data[PERIOD_W+LEN_W-1:PERIOD_W];
                        note_rest_d   = bus.rom_data[PERIOD_W+LEN_W];
                        note_valid_d  = 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.note_ready) begin
                        note_valid_d    = 1'b0;
                        rom_addr_d      = {rom_addr_q[ROM_AW-1:6], rom_addr_q[5:0] + 6'd1};
                        ovf_d           = (rom_addr_q[5:0] == 6'h3f);
                        pause_pending_d = 1'b0;
                    end else begin
                        note_valid_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q      <= '0;
            note_valid_q    <= 1'b0;
            note_period_q   <= '0;
            note_len_q      <= '0;
            note_rest_q     <= 1'b0;
            song_idx_q      <= 2'd0;
            playing_q       <= 1'b0;
            song_done_q     <= 1'b0;
            pause_pending_q <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            rom_addr_q      <= rom_addr_d;
            note_valid_q    <= note_valid_d;
            note_period_q   <= note_period_d;
            note_len_q      <= note_len_d;
            note_rest_q     <= note_rest_d;
            song_idx_q      <= song_idx_d;
            playing_q       <= playing_d;
            song_done_q     <= song_done_d;
            pause_pending_q <= pause_pending_d;
            ovf_q           <= ovf_d;
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.note_valid  = note_valid_q;
    assign bus.note_period = note_period_q;
    assign bus.note_len    = note_len_q;
    assign bus.note_rest   = note_rest_q;
    assign song_idx        = song_idx_q;
    assign playing         = playing_q;
    assign song_done       = song_done_q;
endmodule

// File: doc/song_sequencer.md
# song_sequencer

Playback controller for the buzzer tone path: owns song selection, play/pause and note sequencing. Fetches note entries from an external score ROM and hands each note (period, length, rest flag) to the downstream tone generator over a valid/ready handshake. Sits between the debounced front-panel buttons and the tone generator that drives `buzzer`.

## Interface
Parameters:
- `ROM_AW`, 8: score ROM address width; each song occupies a 64-entry slot at base `song_idx*64`.
- `PERIOD_W`, 17: note period width, in clk cycles per tone period.
- `LEN_W`, 11: note length width, in tone periods.
- `NUM_SONGS`, 3: number of songs, range 1..4.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `btn_next` in 1: one-cycle pulse that selects the next song (debounced upstream).
- `btn_play` in 1: one-cycle pulse that toggles play/pause.
- `rom_addr` out `ROM_AW`: score ROM address.
- `rom_data` in `PERIOD_W+LEN_W+2`: entry `{eos, rest, len, period}`, valid 1 cycle after `rom_addr`.
- `note_valid` out 1: note offered to the tone generator.
- `note_ready` in 1: tone generator accepts the note.
- `note_period` out `PERIOD_W`: period of the offered note.
- `note_len` out `LEN_W`: length of the offered note.
- `note_rest` out 1: offered note is silent.
- `song_idx` out 2: current song.
- `playing` out 1: 1 when playing, 0 when paused or idle.
- `song_done` out 1: one-cycle pulse at end of song.

## Operation
- States: IDLE, FETCH, LATCH, ISSUE, PAUSED.
- Reset values: state IDLE, `song_idx`=0, `rom_addr`=0, `note_valid`=0, `note_period`/`note_len`/`note_rest`=0, `playing`=0, `song_done`=0.
- IDLE:
  - `btn_play` sets `rom_addr` to the song base and `playing`=1, then goes to FETCH.
- FETCH:
  - Drives `rom_addr` for one cycle, then goes to LATCH.
- LATCH:
  - Registers `rom_data`.
  - If `eos`=1, the entry is not issued; end-of-song handling applies.
  - Otherwise loads the note outputs and goes to ISSUE.
- ISSUE:
  - Holds `note_valid`=1 and stable note outputs until `note_ready`.
  - On handshake: `rom_addr`+1, then FETCH, or PAUSED if a pause is pending.
- Pause:
  - `btn_play` while playing sets `pause_pending` and `playing`=0.
  - Takes effect at the next FETCH boundary. A note already in ISSUE completes its handshake first.
  - `btn_play` in PAUSED: `playing`=1, then FETCH at the same `rom_addr`.
- `btn_next`, in any state:
  - `song_idx` = (`song_idx`+1) mod `NUM_SONGS`; `rom_addr` = new base; `pause_pending` cleared.
  - State becomes FETCH if `playing`=1, otherwise IDLE.
  - `note_valid` drops the next cycle. Note withdrawal is permitted only on `btn_next`, and the tone generator discards withdrawn notes.
- `btn_next` and `btn_play` in the same cycle: next is applied first, then `playing` toggles.
- Slot overflow: an entry at offset 63 that is accepted without `eos` is treated as `eos` on the following step.
- Width rule: the base address is `{song_idx, 6'b0}`. The offset wraps within 6 bits, never into the neighbouring slot.

## Timing
- FETCH to `note_valid`=1: 2 cycles.
- Handshake at cycle t: next `note_valid` no earlier than t+3.
- `song_done` is asserted the cycle after LATCH sees `eos`.
- Button effects register on the cycle after the pulse.
- `rst` mid-note returns all outputs to reset values on the next edge, regardless of handshake state.

## Configuration
- Macro: `SONG_LOOP_EN`.
- Defined:
  - On `eos`, pulse `song_done`, reload `rom_addr` to the song base and go to FETCH.
  - `playing` stays 1.
- Undefined:
  - On `eos`, pulse `song_done`, set `playing`=0, go to IDLE, and reload `rom_addr` to the base.

## Test plan
- Reset, `btn_play`, ROM song 0 = {mi 36407/165, re 40872/146, eos}, `note_ready`=1 → two handshakes with those values, then `song_done`; IDLE with `playing`=0 without the macro, replays mi with the macro.
- `note_ready` low for 20 cycles in ISSUE → `note_valid` and note fields held stable for all 20 cycles, exactly one handshake.
- `btn_play` during ISSUE of note 3 → note 3 completes, no fetch follows, `playing`=0; second `btn_play` → note 4 issued at `rom_addr`=base+4.
- `btn_next` mid-ISSUE with `song_idx`=2, `NUM_SONGS`=3 → `note_valid` drops next cycle, `song_idx`=0, `rom_addr`=0, FETCH.
- Song 1 slot with no `eos` in 64 entries → 64 handshakes, `song_done`, `rom_addr` never reaches 128.
- `rst` asserted one cycle during ISSUE → all outputs 0 and IDLE on the next edge.
